// File: rtl/data_bank_arb_pkg.sv
// Shared types and defaults for the data bank arbiter and its read response slot.
package data_bank_arb_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PEND  = 2'd1,
        HOLD  = 2'd2
    } rsp_state_t;

    localparam int MAX_WAIT_DEFAULT = 4;
    localparam int STARVE_CNT_WIDTH = 4;

endpackage

// File: rtl/data_bank_rsp_slot.sv
// Single-entry read response slot: presents RAM data the cycle after a read grant
// and parks it in a hold register while the consumer stalls.
module data_bank_rsp_slot
    import data_bank_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_gnt,
    input  logic                  rd_rready,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  rd_eligible,
    output logic                  rd_rvalid,
    output logic [DATA_WIDTH-1:0] rd_rdata
);

    rsp_state_t            state;
    logic [DATA_WIDTH-1:0] hold_data;

    // A new read may only launch when the slot will be free by the next edge.
    assign rd_eligible = (state == EMPTY) || rd_rready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            hold_data <= '0;
            rd_rvalid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (rd_gnt) begin
                        state     <= PEND;
                        rd_rvalid <= 1'b1;
                    end
                end
                PEND: begin
                    if (rd_rready) begin
                        state     <= rd_gnt ? PEND : EMPTY;
                        rd_rvalid <= rd_gnt;
                    end else begin
                        // RAM output is only valid for one cycle, so capture it now.
                        hold_data <= ram_rdata;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (rd_rready) begin
                        state     <= rd_gnt ? PEND : EMPTY;
                        rd_rvalid <= rd_gnt;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    rd_rvalid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_rdata = '0;
        case (state)
            PEND:    rd_rdata = ram_rdata;
            HOLD:    rd_rdata = hold_data;
            default: rd_rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_bank_arbiter.sv
// Arbitrates a refill write port and a lookup read port onto one single-port RAM,
// favouring writes but forcing a read through after MAX_WAIT denials.
module data_bank_arbiter
    import data_bank_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 6,
    parameter int MAX_WAIT   = MAX_WAIT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_req,
    output logic                    wr_gnt,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_wdata,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_req,
    output logic                    rd_gnt,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_rvalid,
    input  logic                    rd_rready,
    output logic [DATA_WIDTH-1:0]   rd_rdata,
    output logic                    ram_req,
    output logic                    ram_write,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    output logic [DATA_WIDTH/8-1:0] ram_be,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    localparam logic [STARVE_CNT_WIDTH-1:0] WAIT_LIMIT = STARVE_CNT_WIDTH'(MAX_WAIT);

    logic [STARVE_CNT_WIDTH-1:0] starve_cnt;
    logic                        rd_eligible;
    logic                        rd_waiting;
    logic                        rd_wins;

    assign rd_waiting = rd_req && rd_eligible;
    assign rd_wins    = rd_waiting && (!wr_req || (starve_cnt == WAIT_LIMIT));

    // Grants are gated by reset so nothing reaches the RAM while it is asserted.
    assign rd_gnt = rd_wins && !rst;
    assign wr_gnt = wr_req && !rd_wins && !rst;

    assign ram_req   = wr_gnt || rd_gnt;
    assign ram_write = wr_gnt;
    assign ram_addr  = rd_gnt ? rd_addr : wr_addr;
    assign ram_wdata = wr_gnt ? wr_wdata : '0;
    assign ram_be    = wr_gnt ? wr_be : '0;

    // Counts only denials the read could actually have taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (rd_gnt) begin
            starve_cnt <= '0;
        end else if (rd_waiting && (starve_cnt != WAIT_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    data_bank_rsp_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_slot (
        .clk         (clk),
        .rst         (rst),
        .rd_gnt      (rd_gnt),
        .rd_rready   (rd_rready),
        .ram_rdata   (ram_rdata),
        .rd_eligible (rd_eligible),
        .rd_rvalid   (rd_rvalid),
        .rd_rdata    (rd_rdata)
    );

endmodule

// File: doc/data_bank_arbiter.md
DATA_BANK_ARBITER -- requirements
Module: data_bank_arbiter

Interface
REQ-001 Parameters SHALL be DATA_WIDTH, default 128, RAM word width; ADDR_WIDTH, default 6, RAM word address width; MAX_WAIT, default 4, consecutive read denials before forced read grant (range 1..15).
REQ-002 clk  input  1  single clock; all state rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 wr_req  input  1  refill write request (data to be written).
REQ-005 wr_gnt  output  1  write accepted this cycle (combinational).
REQ-006 wr_addr  input  ADDR_WIDTH  write word address.
REQ-007 wr_wdata  input  DATA_WIDTH  write data.
REQ-008 wr_be  input  DATA_WIDTH/8  write byte enables.
REQ-009 rd_req  input  1  lookup read request.
REQ-010 rd_gnt  output  1  read accepted this cycle (combinational).
REQ-011 rd_addr  input  ADDR_WIDTH  read word address.
REQ-012 rd_rvalid  output  1  read response valid.
REQ-013 rd_rready  input  1  consumer accepts response.
REQ-014 rd_rdata  output  DATA_WIDTH  read response data.
REQ-015 ram_req, ram_write  output  1 each  single-port RAM strobe and write select.
REQ-016 ram_addr  output  ADDR_WIDTH; ram_wdata  output  DATA_WIDTH; ram_be  output  DATA_WIDTH/8.
REQ-017 ram_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after a read strobe.

Function
REQ-018 At most one of wr_gnt, rd_gnt SHALL be high per cycle; ram_req SHALL equal wr_gnt | rd_gnt; ram_write SHALL equal wr_gnt.
REQ-019 ram_addr/ram_wdata/ram_be SHALL carry the granted requester's fields; ram_be SHALL be all-zero on reads.
REQ-020 rd_gnt SHALL be allowed only when read-eligible: response slot empty, or slot valid and rd_rready high this cycle.
REQ-021 Priority: write wins by default; a waiting eligible read wins when starve_cnt == MAX_WAIT.
REQ-022 starve_cnt SHALL increment (saturating at MAX_WAIT) each cycle rd_req is high, read-eligible and not granted; clear on rd_gnt; hold otherwise.
REQ-023 Response FSM states: EMPTY, PEND (RAM access in flight), HOLD (data captured, awaiting rready).
REQ-024 EMPTY->PEND on rd_gnt; PEND: rd_rvalid=1, rd_rdata=ram_rdata; if rd_rready -> EMPTY (or PEND on new rd_gnt), else capture ram_rdata into hold register -> HOLD.
REQ-025 HOLD: rd_rvalid=1, rd_rdata=hold register; rd_rready -> EMPTY, or PEND if rd_gnt same cycle.
REQ-026 Read-to-response latency SHALL be exactly 1 cycle when rd_rready is high; back-to-back reads SHALL sustain one per cycle.
REQ-027 Write granted while in HOLD SHALL NOT alter held data, even to the same address.
REQ-028 Write and read to the same address in the same cycle: write wins (unless starved), the read then returns the new data.
REQ-029 Requesters SHALL hold req and fields stable until granted; the arbiter does not register requests.

Reset
REQ-030 On rst: FSM=EMPTY, starve_cnt=0, hold register=0; rd_rvalid=0, rd_rdata=0, ram_req=0, ram_write=0, grants 0 while rst high.
REQ-031 rst mid-access SHALL discard any in-flight read; no rd_rvalid after deassertion until a new rd_gnt.

Structure
REQ-032 FSM state typedef (EMPTY/PEND/HOLD) and MAX_WAIT default SHALL live in shared package data_bank_arb_pkg.
REQ-033 Response slot (FSM + hold register) SHALL be sub-module data_bank_rsp_slot; arbitration and counter stay in the top.

Verification
REQ-034 wr_req and rd_req both high continuously, rd_rready=1, MAX_WAIT=4 -> 4 write grants, 1 read grant, repeating; no cycle with both grants.
REQ-035 Read addr 5 (RAM holds 0xA5), rd_rready=1 -> rd_rvalid high next cycle with rd_rdata=0xA5.
REQ-036 Read addr 3 (0x33), rd_rready=0 for 3 cycles while write 0xFF to addr 3 granted -> rd_rdata stays 0x33 until rready; rd_gnt low throughout.
REQ-037 Same-cycle write 0x77 and read addr 9 (starve_cnt=0) -> write first; read next cycle returns 0x77.
REQ-038 Read granted, rst asserted in PEND cycle -> rd_rvalid=0, starve_cnt=0 after reset; no stale response.
REQ-039 Reads every cycle to addr 0..7, rd_rready=1, no writes -> 8 responses in 8 consecutive cycles, in order.
